// File: rtl/alu_seq_pkg.sv
// Shared types and default widths for the ALU command sequencer.
//   cmd_t   : one queued command {mode, op, a, b}
//   state_e : sequencer FSM encoding
package alu_seq_pkg;

    localparam int unsigned DATA_W      = 8;
    localparam int unsigned OPA_W       = 3;
    localparam int unsigned OPB_W       = 2;
    localparam int unsigned DEF_DEPTH   = 4;
    localparam int unsigned DEF_ALU_LAT = 1;

    typedef struct packed {
        logic              mode;   // 0 = op set A, 1 = op set B
        logic [OPA_W-1:0]  op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command, response and ALU-pin bundle of the ALU command sequencer.
//   slave  : sequencer side (takes commands, drives the ALU, returns responses)
//   master : environment side (command producer, ALU, response consumer)
interface alu_cmd_sequencer_if;
    import alu_seq_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_mode;
    logic [OPA_W-1:0]  cmd_op;
    logic [DATA_W-1:0] cmd_a;
    logic [DATA_W-1:0] cmd_b;

    logic              alu_enable;
    logic              alu_enable_a;
    logic              alu_enable_b;
    logic [OPA_W-1:0]  alu_op_a;
    logic [OPB_W-1:0]  alu_op_b;
    logic [DATA_W-1:0] alu_in_a;
    logic [DATA_W-1:0] alu_in_b;
    logic              alu_irq_clr;
    logic [DATA_W-1:0] alu_out;
    logic              alu_irq;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_irq;

    modport slave (
        input  cmd_valid, cmd_mode, cmd_op, cmd_a, cmd_b,
        output cmd_ready,
        output alu_enable, alu_enable_a, alu_enable_b, alu_op_a, alu_op_b,
        output alu_in_a, alu_in_b, alu_irq_clr,
        input  alu_out, alu_irq,
        output rsp_valid, rsp_data, rsp_irq,
        input  rsp_ready
    );

    modport master (
        output cmd_valid, cmd_mode, cmd_op, cmd_a, cmd_b,
        input  cmd_ready,
        input  alu_enable, alu_enable_a, alu_enable_b, alu_op_a, alu_op_b,
        input  alu_in_a, alu_in_b, alu_irq_clr,
        output alu_out, alu_irq,
        input  rsp_valid, rsp_data, rsp_irq,
        output rsp_ready
    );

endinterface

// File: rtl/alu_seq_fifo.sv
// Synchronous command FIFO of cmd_t entries.
//   clk, rst_n      : clock, synchronous active-low reset (flushes pointers/level)
//   push, push_data : write an entry (caller guarantees !full)
//   pop, head       : head entry is visible combinationally; pop advances it
//   full, empty     : occupancy flags
//   level           : occupancy count
module alu_seq_fifo
    import alu_seq_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  cmd_t                     push_data,
    input  logic                     pop,
    output cmd_t                     head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    cmd_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] cnt;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + LW'(1);
                2'b01:   cnt <= cnt - LW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage needs no reset; validity is tracked by cnt.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign full  = (cnt == LW'(DEPTH));
    assign empty = (cnt == '0);
    assign level = cnt;

endmodule

// File: rtl/alu_cmd_sequencer.sv
// ALU command sequencer: queues commands, issues them one at a time to the ALU,
// captures result/irq, clears the ALU interrupt and returns a response.
//   alu_clk, rst_n : clock, synchronous active-low reset
//   bus            : alu_cmd_sequencer_if.slave (cmd port, ALU pins, rsp port)
//   busy           : FSM not idle
//   fifo_level     : queued command count
//   stat_cmd_cnt / stat_irq_cnt : saturating response / irq-response counters,
//                    present only when ALU_SEQ_STATS_EN is defined
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned DEPTH   = DEF_DEPTH,
    parameter int unsigned ALU_LAT = DEF_ALU_LAT
) (
    input  logic                   alu_clk,
    input  logic                   rst_n,
    alu_cmd_sequencer_if.slave     bus,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_level
`ifdef ALU_SEQ_STATS_EN
    ,
    output logic [15:0]            stat_cmd_cnt,
    output logic [15:0]            stat_irq_cnt
`endif
);

    localparam int unsigned LAT_W = $clog2(ALU_LAT + 1);

    localparam logic [1:0] S_IDLE  = 2'(IDLE);
    localparam logic [1:0] S_ISSUE = 2'(ISSUE);
    localparam logic [1:0] S_WAIT  = 2'(WAIT);
    localparam logic [1:0] S_RESP  = 2'(RESP);

    logic [1:0]       state, state_n;
    logic [LAT_W-1:0] lat_cnt, lat_cnt_n;
    cmd_t             cmd_q, cmd_n;

    cmd_t             fifo_head;
    cmd_t             fifo_in;
    logic             fifo_full, fifo_empty;
    logic             push_c, pop_c;

    // Registered outputs and their next values
    logic              alu_en_q,    alu_en_n;
    logic              en_a_q,      en_a_n;
    logic              en_b_q,      en_b_n;
    logic [OPA_W-1:0]  op_a_q,      op_a_n;
    logic [OPB_W-1:0]  op_b_q,      op_b_n;
    logic [DATA_W-1:0] in_a_q,      in_a_n;
    logic [DATA_W-1:0] in_b_q,      in_b_n;
    logic              irq_clr_q,   irq_clr_n;
    logic              rsp_valid_q, rsp_valid_n;
    logic [DATA_W-1:0] rsp_data_q,  rsp_data_n;
    logic              rsp_irq_q,   rsp_irq_n;
    logic              busy_q,      busy_n;
    logic              drive_c;

    assign fifo_in = '{mode: bus.cmd_mode, op: bus.cmd_op, a: bus.cmd_a, b: bus.cmd_b};
    assign push_c  = bus.cmd_valid && !fifo_full;

    alu_seq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (alu_clk),
        .rst_n     (rst_n),
        .push      (push_c),
        .push_data (fifo_in),
        .pop       (pop_c),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    // Next state, command latch, response capture and next output values
    always_comb begin
        state_n    = state;
        lat_cnt_n  = lat_cnt;
        cmd_n      = cmd_q;
        pop_c      = 1'b0;
        rsp_data_n = rsp_data_q;
        rsp_irq_n  = rsp_irq_q;
        irq_clr_n  = 1'b0;

        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop_c   = 1'b1;
                    cmd_n   = fifo_head;
                    state_n = S_ISSUE;
                end
            end
            S_ISSUE: begin
                lat_cnt_n = '0;
                state_n   = S_WAIT;
            end
            S_WAIT: begin
                if (lat_cnt == LAT_W'(ALU_LAT - 1)) begin
                    state_n    = S_RESP;
                    rsp_data_n = bus.alu_out;
                    rsp_irq_n  = bus.alu_irq;
                    // Clear pulse lands in the first RESP cycle only
                    irq_clr_n  = bus.alu_irq;
                end else begin
                    lat_cnt_n = lat_cnt + LAT_W'(1);
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase

        // ALU pins are driven while the command is in ISSUE or WAIT
        drive_c     = (state_n == S_ISSUE) || (state_n == S_WAIT);
        alu_en_n    = drive_c;
        en_a_n      = drive_c && !cmd_n.mode;
        en_b_n      = drive_c &&  cmd_n.mode;
        op_a_n      = en_a_n ? cmd_n.op : '0;
        op_b_n      = en_b_n ? cmd_n.op[OPB_W-1:0] : '0;
        in_a_n      = drive_c ? cmd_n.a : '0;
        in_b_n      = drive_c ? cmd_n.b : '0;
        rsp_valid_n = (state_n == S_RESP);
        busy_n      = (state_n != S_IDLE);
    end

    // State and output registers
    always_ff @(posedge alu_clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            lat_cnt     <= '0;
            cmd_q       <= '0;
            alu_en_q    <= 1'b0;
            en_a_q      <= 1'b0;
            en_b_q      <= 1'b0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            in_a_q      <= '0;
            in_b_q      <= '0;
            irq_clr_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_irq_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state       <= state_n;
            lat_cnt     <= lat_cnt_n;
            cmd_q       <= cmd_n;
            alu_en_q    <= alu_en_n;
            en_a_q      <= en_a_n;
            en_b_q      <= en_b_n;
            op_a_q      <= op_a_n;
            op_b_q      <= op_b_n;
            in_a_q      <= in_a_n;
            in_b_q      <= in_b_n;
            irq_clr_q   <= irq_clr_n;
            rsp_valid_q <= rsp_valid_n;
            rsp_data_q  <= rsp_data_n;
            rsp_irq_q   <= rsp_irq_n;
            busy_q      <= busy_n;
        end
    end

    assign bus.cmd_ready    = !fifo_full;
    assign bus.alu_enable   = alu_en_q;
    assign bus.alu_enable_a = en_a_q;
    assign bus.alu_enable_b = en_b_q;
    assign bus.alu_op_a     = op_a_q;
    assign bus.alu_op_b     = op_b_q;
    assign bus.alu_in_a     = in_a_q;
    assign bus.alu_in_b     = in_b_q;
    assign bus.alu_irq_clr  = irq_clr_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_data     = rsp_data_q;
    assign bus.rsp_irq      = rsp_irq_q;
    assign busy             = busy_q;

`ifdef ALU_SEQ_STATS_EN
    logic rsp_hs_c;
    assign rsp_hs_c = rsp_valid_q && bus.rsp_ready;

    // Saturating completion counters
    always_ff @(posedge alu_clk) begin
        if (!rst_n) begin
            stat_cmd_cnt <= '0;
            stat_irq_cnt <= '0;
        end else if (rsp_hs_c) begin
            if (stat_cmd_cnt != 16'hFFFF) stat_cmd_cnt <= stat_cmd_cnt + 16'(1);
            if (rsp_irq_q && (stat_irq_cnt != 16'hFFFF)) stat_irq_cnt <= stat_irq_cnt + 16'(1);
        end
    end
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a registered ALU stub (latency 1).
// Stub: mode A op 0 = a+b, irq set on carry (sticky until alu_irq_clr);
//       mode B op 0 = a^b, op 1 = a&b, no irq.
module tb_alu_cmd_sequencer;
    import alu_seq_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_cmd_sequencer_if bus ();
    logic       busy;
    logic [2:0] fifo_level;
`ifdef ALU_SEQ_STATS_EN
    logic [15:0] stat_cmd_cnt;
    logic [15:0] stat_irq_cnt;
`endif

    alu_cmd_sequencer dut (
        .alu_clk      (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .busy         (busy),
        .fifo_level   (fifo_level)
`ifdef ALU_SEQ_STATS_EN
        ,
        .stat_cmd_cnt (stat_cmd_cnt),
        .stat_irq_cnt (stat_irq_cnt)
`endif
    );

    // ALU stub
    logic [8:0] sum;
    assign sum = {1'b0, bus.alu_in_a} + {1'b0, bus.alu_in_b};
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.alu_out <= '0;
            bus.alu_irq <= 1'b0;
        end else begin
            if (bus.alu_irq_clr) bus.alu_irq <= 1'b0;
            if (bus.alu_enable && bus.alu_enable_a && bus.alu_op_a == 3'd0) begin
                bus.alu_out <= sum[7:0];
                if (sum[8]) bus.alu_irq <= 1'b1;
            end else if (bus.alu_enable && bus.alu_enable_b) begin
                bus.alu_out <= bus.alu_op_b[0] ? (bus.alu_in_a & bus.alu_in_b)
                                               : (bus.alu_in_a ^ bus.alu_in_b);
            end
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input logic mode, input logic [2:0] op,
                           input logic [7:0] a, input logic [7:0] b);
        bus.cmd_valid = 1'b1;
        bus.cmd_mode  = mode;
        bus.cmd_op    = op;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
    endtask

    // One-cycle command; returns 1ns after the accepting edge e0
    task automatic send_cmd(input logic mode, input logic [2:0] op,
                            input logic [7:0] a, input logic [7:0] b);
        set_cmd(mode, op, a, b);
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    logic       t4_m   [6];
    logic [2:0] t4_op  [6];
    logic [7:0] t4_a   [6];
    logic [7:0] t4_b   [6];
    logic [7:0] t4_exp [6];

    initial begin
        int got;
        int got_at_acc;
        int sent;
        int vcnt;
        int ccnt;
        logic acc;
        logic hs;

        rst_n         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_mode  = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_a     = '0;
        bus.cmd_b     = '0;
        bus.rsp_ready = 1'b0;

        // 1. reset
        tick();
        tick();
        rst_n = 1'b1;
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_alu_enable", 32'(bus.alu_enable), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        // 2. mode A add, no carry
        bus.rsp_ready = 1'b1;
        send_cmd(1'b0, 3'd0, 8'h12, 8'h34);
        check("t2_e0_enable", 32'(bus.alu_enable), 32'd0);
        check("t2_e0_level", 32'(fifo_level), 32'd1);
        tick();
        check("t2_e1_en_a", 32'(bus.alu_enable_a), 32'd1);
        check("t2_e1_en_b", 32'(bus.alu_enable_b), 32'd0);
        check("t2_e1_op_a", 32'(bus.alu_op_a), 32'd0);
        check("t2_e1_in_a", 32'(bus.alu_in_a), 32'h12);
        check("t2_e1_in_b", 32'(bus.alu_in_b), 32'h34);
        check("t2_e1_busy", 32'(busy), 32'd1);
        check("t2_e1_level", 32'(fifo_level), 32'd0);
        tick();
        check("t2_e2_en_a", 32'(bus.alu_enable_a), 32'd1);
        check("t2_e2_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        tick();
        check("t2_e3_enable", 32'(bus.alu_enable), 32'd0);
        check("t2_e3_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("t2_e3_rsp_data", 32'(bus.rsp_data), 32'h46);
        check("t2_e3_rsp_irq", 32'(bus.rsp_irq), 32'd0);
        check("t2_e3_irq_clr", 32'(bus.alu_irq_clr), 32'd0);
        tick();
        check("t2_e4_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("t2_e4_busy", 32'(busy), 32'd0);

        // 2b. mode B: op 3'b101 truncates to op_b=1 (AND)
        send_cmd(1'b1, 3'b101, 8'h3C, 8'h0F);
        tick();
        check("t2b_en_a", 32'(bus.alu_enable_a), 32'd0);
        check("t2b_en_b", 32'(bus.alu_enable_b), 32'd1);
        check("t2b_op_a", 32'(bus.alu_op_a), 32'd0);
        check("t2b_op_b", 32'(bus.alu_op_b), 32'd1);
        tick();
        tick();
        check("t2b_rsp_data", 32'(bus.rsp_data), 32'h0C);
        tick();

        // 3. carry -> irq and a single clear pulse
        bus.rsp_ready = 1'b0;
        send_cmd(1'b0, 3'd0, 8'hF0, 8'h20);
        tick();
        tick();
        check("t3_e2_irq_clr", 32'(bus.alu_irq_clr), 32'd0);
        tick();
        check("t3_e3_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("t3_e3_rsp_data", 32'(bus.rsp_data), 32'h10);
        check("t3_e3_rsp_irq", 32'(bus.rsp_irq), 32'd1);
        check("t3_e3_irq_clr", 32'(bus.alu_irq_clr), 32'd1);
        tick();
        check("t3_e4_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("t3_e4_irq_clr", 32'(bus.alu_irq_clr), 32'd0);
        check("t3_e4_rsp_data", 32'(bus.rsp_data), 32'h10);
        check("t3_e4_rsp_irq", 32'(bus.rsp_irq), 32'd1);
        bus.rsp_ready = 1'b1;
        tick();
        check("t3_e5_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("t3_e5_irq_clr", 32'(bus.alu_irq_clr), 32'd0);
`ifdef ALU_SEQ_STATS_EN
        check("stat_cmd_cnt", 32'(stat_cmd_cnt), 32'd3);
        check("stat_irq_cnt", 32'(stat_irq_cnt), 32'd1);
`endif

        // 4. back-pressure: 5 accepted, 6th waits for a free slot
        t4_m[0] = 1'b0; t4_op[0] = 3'd0;   t4_a[0] = 8'h01; t4_b[0] = 8'h02; t4_exp[0] = 8'h03;
        t4_m[1] = 1'b1; t4_op[1] = 3'b100; t4_a[1] = 8'h0F; t4_b[1] = 8'hF0; t4_exp[1] = 8'hFF;
        t4_m[2] = 1'b0; t4_op[2] = 3'd0;   t4_a[2] = 8'h10; t4_b[2] = 8'h20; t4_exp[2] = 8'h30;
        t4_m[3] = 1'b1; t4_op[3] = 3'b100; t4_a[3] = 8'hAA; t4_b[3] = 8'h0F; t4_exp[3] = 8'hA5;
        t4_m[4] = 1'b0; t4_op[4] = 3'd0;   t4_a[4] = 8'h7F; t4_b[4] = 8'h01; t4_exp[4] = 8'h80;
        t4_m[5] = 1'b0; t4_op[5] = 3'd0;   t4_a[5] = 8'h05; t4_b[5] = 8'h06; t4_exp[5] = 8'h0B;
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t4_ready_%0d", i), 32'(bus.cmd_ready), 32'd1);
            set_cmd(t4_m[i], t4_op[i], t4_a[i], t4_b[i]);
            tick();
        end
        set_cmd(t4_m[5], t4_op[5], t4_a[5], t4_b[5]);
        check("t4_full_ready", 32'(bus.cmd_ready), 32'd0);
        check("t4_full_level", 32'(fifo_level), 32'd4);
        tick();
        tick();
        check("t4_hold_ready", 32'(bus.cmd_ready), 32'd0);
        check("t4_hold_level", 32'(fifo_level), 32'd4);
        check("t4_hold_rsp_valid", 32'(bus.rsp_valid), 32'd1);

        bus.rsp_ready = 1'b1;
        got        = 0;
        got_at_acc = -1;
        sent       = 5;
        for (int cyc = 0; cyc < 200 && got < 6; cyc++) begin
            acc = bus.cmd_valid && bus.cmd_ready;
            hs  = bus.rsp_valid && bus.rsp_ready;
            if (hs) begin
                check($sformatf("t4_rsp_data_%0d", got), 32'(bus.rsp_data), 32'(t4_exp[got]));
                check($sformatf("t4_rsp_irq_%0d", got), 32'(bus.rsp_irq), 32'd0);
                got++;
            end
            if (acc) begin
                got_at_acc = got;
                sent++;
            end
            tick();
            if (acc) bus.cmd_valid = 1'b0;
        end
        check("t4_rsp_count", 32'(got), 32'd6);
        check("t4_sent_count", 32'(sent), 32'd6);
        check("t4_accept_after_1st_rsp", 32'(got_at_acc), 32'd1);
        check("t4_end_level", 32'(fifo_level), 32'd0);
        tick();
        check("t4_end_busy", 32'(busy), 32'd0);

        // 5. reset during WAIT aborts the in-flight command and flushes the queue
        bus.rsp_ready = 1'b1;
        set_cmd(1'b0, 3'd0, 8'hF0, 8'h20);
        tick();
        set_cmd(1'b0, 3'd0, 8'h01, 8'h01);
        tick();
        bus.cmd_valid = 1'b0;
        check("t5_pre_level", 32'(fifo_level), 32'd1);
        tick();
        check("t5_in_wait_en", 32'(bus.alu_enable), 32'd1);
        rst_n = 1'b0;
        tick();
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_alu_enable", 32'(bus.alu_enable), 32'd0);
        check("t5_level", 32'(fifo_level), 32'd0);
        check("t5_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("t5_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        rst_n = 1'b1;
        vcnt = 0;
        ccnt = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            tick();
            if (bus.rsp_valid)   vcnt++;
            if (bus.alu_irq_clr) ccnt++;
        end
        check("t5_no_rsp", 32'(vcnt), 32'd0);
        check("t5_no_irq_clr", 32'(ccnt), 32'd0);
        check("t5_idle_busy", 32'(busy), 32'd0);
`ifdef ALU_SEQ_STATS_EN
        check("stat_cmd_rst", 32'(stat_cmd_cnt), 32'd0);
        check("stat_irq_rst", 32'(stat_irq_cnt), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
